// File: rtl/aes_pkg.sv
// Shared AES datapath types, GF(2^8) helpers and the row/mix stage FSM encoding.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1b;

  typedef logic [15:0][7:0] aes_state_t;
  typedef logic [3:0][7:0]  aes_col_t;

  typedef enum logic [1:0] {IDLE, MIX, HOLD} rowmix_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Sum of a*x^i for each set bit i of b; the reduction comes from xtime.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] acc;
    p   = a;
    acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_inv_rowmix_if.sv
// Valid/ready handshake on both sides of the InvShiftRows/InvMixColumns stage.
interface aes_inv_rowmix_if;
  import aes_pkg::*;

  logic       in_valid;
  logic       in_ready;
  aes_state_t in_state;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  aes_state_t out_state;

  modport master (output in_valid, in_state, in_last, out_ready,
                  input  in_ready, out_valid, out_state);
  modport slave  (input  in_valid, in_state, in_last, out_ready,
                  output in_ready, out_valid, out_state);
endinterface

// File: rtl/aes_inv_rowmix_mixcol.sv
// Combinational InvMixColumns on one column; i_col[3] is row 0, i_col[0] is row 3.
module inv_mixcolumn
  import aes_pkg::*;
(
  input  aes_col_t i_col,
  output aes_col_t o_col
);
  logic [7:0] w_s0, w_s1, w_s2, w_s3;

  assign w_s0 = i_col[3];
  assign w_s1 = i_col[2];
  assign w_s2 = i_col[1];
  assign w_s3 = i_col[0];

  assign o_col[3] = gmul(w_s0, 8'h0e) ^ gmul(w_s1, 8'h0b) ^ gmul(w_s2, 8'h0d) ^ gmul(w_s3, 8'h09);
  assign o_col[2] = gmul(w_s0, 8'h09) ^ gmul(w_s1, 8'h0e) ^ gmul(w_s2, 8'h0b) ^ gmul(w_s3, 8'h0d);
  assign o_col[1] = gmul(w_s0, 8'h0d) ^ gmul(w_s1, 8'h09) ^ gmul(w_s2, 8'h0e) ^ gmul(w_s3, 8'h0b);
  assign o_col[0] = gmul(w_s0, 8'h0b) ^ gmul(w_s1, 8'h0d) ^ gmul(w_s2, 8'h09) ^ gmul(w_s3, 8'h0e);
endmodule

// File: rtl/aes_inv_rowmix.sv
// Decrypt round stage: InvShiftRows on capture, then InvMixColumns over 4/N cycles.
// Byte (row r, col c) lives at index {3-r, 3-c} of the 16-byte state.
module aes_inv_rowmix
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  aes_inv_rowmix_if.slave  bus
);
  localparam int N = COLS_PER_CYCLE;

  rowmix_state_e r_state;
  aes_state_t    r_work;
  logic [1:0]    r_col_cnt;
  logic          r_last;
  logic          r_in_ready;
  logic          r_out_valid;

  aes_state_t    w_isr;
  aes_state_t    w_mix_work;
  aes_col_t      w_col_in  [N];
  aes_col_t      w_col_out [N];
  logic [1:0]    w_idx     [N];
  logic          w_mix_done;

  // InvShiftRows: new(r,c) = old(r,(c-r) mod 4), pure wiring.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign w_isr[15-4*r-c] = bus.in_state[15-4*r-((c-r+4)%4)];
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_mix
    assign w_idx[k] = r_col_cnt + 2'(k);
    inv_mixcolumn u_mix (.i_col(w_col_in[k]), .o_col(w_col_out[k]));
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      for (int rr = 0; rr < 4; rr++) begin
        w_col_in[k][3-rr] = r_work[{2'(3-rr), ~w_idx[k]}];
      end
    end
  end

  always_comb begin
    w_mix_work = r_work;
    for (int k = 0; k < N; k++) begin
      for (int rr = 0; rr < 4; rr++) begin
        w_mix_work[{2'(3-rr), ~w_idx[k]}] = w_col_out[k][3-rr];
      end
    end
  end

  // A final-round state never enters MIX; r_last only guards against that.
  assign w_mix_done = ((3'(r_col_cnt) + 3'(N)) == 3'd4) || r_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_col_cnt   <= '0;
      r_last      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_work     <= w_isr;
          r_last     <= bus.in_last;
          r_col_cnt  <= '0;
          r_in_ready <= 1'b0;
          if (bus.in_last) begin
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
          end else begin
            r_state <= MIX;
          end
        end
        MIX: begin
          r_work    <= w_mix_work;
          r_col_cnt <= r_col_cnt + 2'(N);
          if (w_mix_done) begin
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
          end
        end
        HOLD: if (bus.out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_state = r_work;
endmodule

// File: tb/tb_aes_inv_rowmix.sv
// Scoreboard bench for aes_inv_rowmix at N=1 (main), N=2 and N=4.
module tb_aes_inv_rowmix;
  import aes_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid_v [3];
  aes_state_t in_state;
  logic       in_last;
  logic       out_ready;
  logic       rdy [3];
  logic       ov  [3];
  aes_state_t os  [3];

  int total = 0;
  int bad   = 0;
  aes_state_t sb[$];

  always #5 clk = ~clk;

  aes_inv_rowmix_if bus1 ();
  aes_inv_rowmix_if bus2 ();
  aes_inv_rowmix_if bus4 ();

  assign bus1.in_valid = in_valid_v[0];
  assign bus2.in_valid = in_valid_v[1];
  assign bus4.in_valid = in_valid_v[2];
  assign bus1.in_state = in_state;
  assign bus2.in_state = in_state;
  assign bus4.in_state = in_state;
  assign bus1.in_last = in_last;
  assign bus2.in_last = in_last;
  assign bus4.in_last = in_last;
  assign bus1.out_ready = out_ready;
  assign bus2.out_ready = out_ready;
  assign bus4.out_ready = out_ready;
  assign rdy[0] = bus1.in_ready;
  assign rdy[1] = bus2.in_ready;
  assign rdy[2] = bus4.in_ready;
  assign ov[0] = bus1.out_valid;
  assign ov[1] = bus2.out_valid;
  assign ov[2] = bus4.out_valid;
  assign os[0] = bus1.out_state;
  assign os[1] = bus2.out_state;
  assign os[2] = bus4.out_state;

  aes_inv_rowmix #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  aes_inv_rowmix #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));
  aes_inv_rowmix #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

  // Reference model, written straight from the FIPS-197 definitions.
  function automatic logic [7:0] gm(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    while (b != 8'h00) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic aes_state_t isr_ref(input aes_state_t s);
    aes_state_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[15-4*r-c] = s[15-4*r-((c-r+4)%4)];
    return o;
  endfunction

  function automatic aes_state_t imc_ref(input aes_state_t s);
    aes_state_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[15-c]; a1 = s[11-c]; a2 = s[7-c]; a3 = s[3-c];
      o[15-c] = gm(8'h0e, a0) ^ gm(8'h0b, a1) ^ gm(8'h0d, a2) ^ gm(8'h09, a3);
      o[11-c] = gm(8'h09, a0) ^ gm(8'h0e, a1) ^ gm(8'h0b, a2) ^ gm(8'h0d, a3);
      o[7-c]  = gm(8'h0d, a0) ^ gm(8'h09, a1) ^ gm(8'h0e, a2) ^ gm(8'h0b, a3);
      o[3-c]  = gm(8'h0b, a0) ^ gm(8'h0d, a1) ^ gm(8'h09, a2) ^ gm(8'h0e, a3);
    end
    return o;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Returns one cycle after the accepting edge, i.e. in cycle T+1.
  task automatic send(input int d, input aes_state_t s, input logic l);
    bit ok;
    ok = 1'b0;
    in_state = s; in_last = l; in_valid_v[d] = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (rdy[d] === 1'b1) ok = 1'b1;
      step();
    end
    in_valid_v[d] = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL send_timeout dut=%0d in_ready never seen", d); end
  endtask

  // lat is the cycle offset from the input handshake; rdy_hi flags in_ready=1 while waiting.
  task automatic wait_out(input int d, output int lat, output aes_state_t st, output bit rdy_hi);
    lat = 1; rdy_hi = 1'b0;
    while (ov[d] !== 1'b1 && lat < 60) begin
      if (rdy[d] !== 1'b0) rdy_hi = 1'b1;
      step(); lat++;
    end
    if (ov[d] !== 1'b1) lat = -1;
    if (rdy[d] !== 1'b0) rdy_hi = 1'b1;
    st = os[d];
  endtask

  aes_state_t mixvec, mixexp, srvec, srexp;

  task automatic test_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      total++;
      if (rdy[d] !== 1'b1 || ov[d] !== 1'b0 || os[d] !== '0) begin
        bad++; $display("FAIL reset dut=%0d rdy=%b ov=%b st=%h want rdy=1 ov=0 st=0", d, rdy[d], ov[d], os[d]);
      end
    end
  endtask

  task automatic test_shiftrows();
    int lat; aes_state_t st, e; bit rh;
    out_ready = 1'b1;
    sb.push_back(srexp);
    send(0, srvec, 1'b1);
    wait_out(0, lat, st, rh);
    e = sb.pop_front();
    total++;
    if (lat !== 1) begin bad++; $display("FAIL sr_latency got=%0d want=1", lat); end
    total++;
    if (st !== e) begin bad++; $display("FAIL sr_state got=%h want=%h", st, e); end
    step();
  endtask

  task automatic test_mixcol();
    int lat; aes_state_t st, e; bit rh;
    out_ready = 1'b1;
    sb.push_back(mixexp);
    send(0, mixvec, 1'b0);
    wait_out(0, lat, st, rh);
    e = sb.pop_front();
    total++;
    if (lat !== 5) begin bad++; $display("FAIL mix_latency got=%0d want=5", lat); end
    total++;
    if (rh !== 1'b0) begin bad++; $display("FAIL mix_in_ready got=1 want=0 before out handshake"); end
    total++;
    if (st !== e) begin bad++; $display("FAIL mix_state got=%h want=%h", st, e); end
    step();
    total++;
    if (rdy[0] !== 1'b1) begin bad++; $display("FAIL mix_ready_after got=%b want=1", rdy[0]); end
  endtask

  task automatic test_fixed();
    int lat, want_lat; aes_state_t st, s, e; bit rh;
    out_ready = 1'b1;
    for (int d = 0; d < 3; d++) begin
      want_lat = (d == 0) ? 5 : (d == 1) ? 3 : 2;
      for (int v = 0; v < 2; v++) begin
        for (int i = 0; i < 16; i++) s[i] = (v == 0) ? 8'h01 : 8'h00;
        sb.push_back(s);
        send(d, s, 1'b0);
        wait_out(d, lat, st, rh);
        e = sb.pop_front();
        total++;
        if (lat !== want_lat) begin bad++; $display("FAIL fixed_latency dut=%0d got=%0d want=%0d", d, lat, want_lat); end
        total++;
        if (st !== e) begin bad++; $display("FAIL fixed_state dut=%0d got=%h want=%h", d, st, e); end
        step();
      end
    end
  endtask

  task automatic test_backpressure();
    int lat; aes_state_t st, e, alt; bit rh;
    out_ready = 1'b0;
    sb.push_back(mixexp);
    send(0, mixvec, 1'b0);
    wait_out(0, lat, st, rh);
    e = sb.pop_front();
    total++;
    if (st !== e) begin bad++; $display("FAIL bp_state got=%h want=%h", st, e); end
    for (int i = 0; i < 16; i++) alt[i] = 8'h55;
    for (int c = 0; c < 10; c++) begin
      in_state = alt; in_last = 1'b1; in_valid_v[0] = 1'b1;
      step();
      total++;
      if (ov[0] !== 1'b1 || os[0] !== e || rdy[0] !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d ov=%b rdy=%b st=%h want ov=1 rdy=0 st=%h", c, ov[0], rdy[0], os[0], e);
      end
    end
    in_valid_v[0] = 1'b0; out_ready = 1'b1;
    step();
    total++;
    if (rdy[0] !== 1'b1 || ov[0] !== 1'b0) begin bad++; $display("FAIL bp_release rdy=%b ov=%b want rdy=1 ov=0", rdy[0], ov[0]); end
    sb.push_back(srexp);
    send(0, srvec, 1'b1);
    wait_out(0, lat, st, rh);
    e = sb.pop_front();
    total++;
    if (st !== e) begin bad++; $display("FAIL bp_next got=%h want=%h", st, e); end
    step();
  endtask

  task automatic test_reset_midop();
    int lat; aes_state_t st, e; bit rh;
    out_ready = 1'b1;
    sb.push_back(mixexp);
    send(0, mixvec, 1'b0);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    void'(sb.pop_back());
    total++;
    if (ov[0] !== 1'b0 || rdy[0] !== 1'b1 || os[0] !== '0) begin
      bad++; $display("FAIL midop_reset ov=%b rdy=%b st=%h want ov=0 rdy=1 st=0", ov[0], rdy[0], os[0]);
    end
    sb.push_back(srexp);
    send(0, srvec, 1'b1);
    wait_out(0, lat, st, rh);
    e = sb.pop_front();
    total++;
    if (st !== e) begin bad++; $display("FAIL midop_after got=%h want=%h", st, e); end
    step();
  endtask

  task automatic test_back_to_back();
    int lat; aes_state_t s, st, e; logic l; bit rh; int errs;
    errs = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 16; i++) s[i] = 8'($urandom);
      l = 1'($urandom_range(0, 1));
      sb.push_back(l ? isr_ref(s) : imc_ref(isr_ref(s)));
      send(0, s, l);
      wait_out(0, lat, st, rh);
      e = sb.pop_front();
      total++;
      if (st !== e) begin bad++; $display("FAIL stream n=%0d last=%b got=%h want=%h", n, l, st, e); end
      step();
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL stream_leftover got=%0d want=0", sb.size()); end
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b0; in_last = 1'b0; in_state = '0;
    for (int d = 0; d < 3; d++) in_valid_v[d] = 1'b0;
    for (int i = 0; i < 16; i++) srvec[i] = 8'(i);
    srexp  = {8'h0f, 8'h0e, 8'h0d, 8'h0c, 8'h08, 8'h0b, 8'h0a, 8'h09,
              8'h05, 8'h04, 8'h07, 8'h06, 8'h02, 8'h01, 8'h00, 8'h03};
    mixvec = {{4{8'h8e}}, {4{8'h4d}}, {4{8'ha1}}, {4{8'hbc}}};
    mixexp = {{4{8'hdb}}, {4{8'h13}}, {4{8'h53}}, {4{8'h45}}};
    test_reset();
    test_shiftrows();
    test_mixcol();
    test_fixed();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/aes_inv_rowmix.md
# aes_inv_rowmix

Iterative decryption-datapath stage that applies InvShiftRows followed by InvMixColumns to one 128-bit AES state, in the order used by the FIPS-197 equivalent inverse cipher. It sits between InvSubBytes and AddRoundKey in the decryption round loop. For the final round it applies InvShiftRows only. It uses a valid/ready handshake on both sides and processes one state at a time, computing N columns per cycle.

## Interface
- `COLS_PER_CYCLE`, default 1: number of columns processed by InvMixColumns per cycle. Legal values are 1, 2 and 4.
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: `in_state` and `in_last` are valid.
- `in_ready`  out  1: the block can accept a state.
- `in_state`  in  [15:0][7:0]: input state. Byte (row r, col c) is `in_state[15-4r-c]`.
- `in_last`  in  1: final round. Skip InvMixColumns.
- `out_valid`  out  1: `out_state` is valid.
- `out_ready`  in  1: downstream accepts `out_state`.
- `out_state`  out  [15:0][7:0]: result, in the same byte layout as `in_state`.

## Operation
- **InvShiftRows:** new(r,c) = old(r,(c−r) mod 4). Row 0 is unchanged. Row 1 rotates right by 1, row 2 by 2, row 3 by 3. This is the exact inverse of the encrypt-side row shift.
- **InvMixColumns, per column:**
  - s0' = 0e·s0 ⊕ 0b·s1 ⊕ 0d·s2 ⊕ 09·s3
  - s1' = 09·s0 ⊕ 0e·s1 ⊕ 0b·s2 ⊕ 0d·s3
  - s2' = 0d·s0 ⊕ 09·s1 ⊕ 0e·s2 ⊕ 0b·s3
  - s3' = 0b·s0 ⊕ 0d·s1 ⊕ 09·s2 ⊕ 0e·s3
  - Multiplication is in GF(2^8) with reduction polynomial 0x11b. All arithmetic is 8-bit with no carries.
- **FSM states:** IDLE, MIX, HOLD.
  - **IDLE:** `in_ready`=1. When `in_valid`=1, the block:
    - loads `work` with InvShiftRows(`in_state`);
    - latches `last`;
    - clears `col_cnt` to 0;
    - goes to HOLD if `in_last`=1, otherwise to MIX.
  - **MIX:** each cycle, replaces columns `col_cnt` .. `col_cnt`+N−1 of `work` with their InvMixColumns result, then adds N to `col_cnt`. After the cycle that processes column 3, it goes to HOLD. Columns are processed in order 0→3.
  - **HOLD:** `out_valid`=1 and `out_state`=`work`. When `out_ready`=1, it goes to IDLE.
- `in_ready` is 1 only in IDLE. There is no overlap of input and output transactions. An `in_valid` asserted in MIX or HOLD is ignored.
- `out_state` is stable and equals `work` while `out_valid`=1, regardless of `out_ready`.
- `col_cnt` is a 2-bit counter that wraps at 4. It is don't-care outside MIX.

## Timing
- **Reset values:** FSM=IDLE, `in_ready`=1, `out_valid`=0, `out_state`=0 (`work` cleared), `col_cnt`=0.
- **Latency:** count from input handshake in cycle T.
  - `in_last`=1: `out_valid` in cycle T+1.
  - `in_last`=0: `out_valid` in cycle T+1+4/N (T+5 for N=1, T+3 for N=2, T+2 for N=4).
- **Throughput:** one state per 1+4/N+1 cycles when `out_ready` is held high.
- **Output handshake:** completes in any HOLD cycle with `out_ready`=1. `in_ready` rises in the following cycle.
- **Backpressure:** HOLD persists indefinitely. `work` is frozen.
- **Reset mid-operation (MIX or HOLD):** the pending state is discarded. The next cycle has IDLE, `out_valid`=0 and `work`=0. No partial result is ever presented.
- **Reset overriding a handshake:** reset asserted in the same cycle as an input handshake takes priority, and the input is not captured.

## Structure
- **Shared package `aes_pkg`:**
  - `aes_state_t` ([15:0][7:0]);
  - `aes_col_t` ([3:0][7:0]);
  - functions `xtime` and `gmul`;
  - constant `AES_POLY` = 8'h1b;
  - FSM enum `rowmix_state_e` {IDLE, MIX, HOLD}.
- **Sub-module `inv_mixcolumn`:** combinational, one column in, one column out. It is instantiated N times, and its outputs are muxed into `work` by `col_cnt`.
- InvShiftRows is pure wiring inside the top level.

## Test plan
1. **InvShiftRows only:** `in_state[i]`=i, `in_last`=1 → at T+1 `out_state[15:0]` = {0f,0e,0d,0c, 08,0b,0a,09, 05,04,07,06, 02,01,00,03}.
2. **InvMixColumns vector:** `in_state[15:12]`=8e, `[11:8]`=4d, `[7:4]`=a1, `[3:0]`=bc, `in_last`=0, N=1. Required response:
   - `out_valid` first at T+5;
   - `out_state` rows = db,13,53,45 (every column);
   - `in_ready`=0 from T+1 until the output handshake.
3. **Fixed point:** all bytes 01, `in_last`=0 → output all 01. All bytes 00 → output all 00. Repeat for N=1, 2, 4 and check latency T+5, T+3, T+2 respectively.
4. **Backpressure:** run scenario 2 with `out_ready`=0 for 10 cycles in HOLD.
   - `out_valid` stays 1 and `out_state` stays constant.
   - `in_valid`=1 with a different state during HOLD is not accepted.
   - After `out_ready`=1, the next state is accepted in IDLE.
5. **Reset mid-op:** assert `reset` in the third MIX cycle → next cycle `out_valid`=0, `in_ready`=1, `out_state`=0. A following scenario-1 input then produces the scenario-1 result.
6. **Back-to-back stream:** 20 random states with random `in_last` and `out_ready` held high. Outputs must match a reference model of InvMixColumns∘InvShiftRows (or InvShiftRows only when `in_last`=1), in order, with no drops or duplicates.
